// File: rtl/count_monitor_pkg.sv
// count_monitor_pkg: shared types and constants for the counter monitor
package count_monitor_pkg;
  typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED} state_t;
  typedef enum logic [1:0] {HOLD, UP, DOWN, ILLEGAL} delta_t;
  localparam logic [15:0] ERR_COUNT_MAX = 16'hFFFF;
endpackage

// File: rtl/count_delta_classify.sv
// count_delta_classify: combinational step classifier for successive counter samples
//   i_prev      : previous sample (reference)
//   i_count     : current sample
//   o_class     : delta class (HOLD/UP/DOWN/ILLEGAL encoded as delta_t)
//   o_wrap_up   : all-ones -> 0 transition (tied 0 unless COUNT_MONITOR_WRAP_FLAG_EN)
//   o_wrap_down : 0 -> all-ones transition (tied 0 unless COUNT_MONITOR_WRAP_FLAG_EN)
module count_delta_classify
  import count_monitor_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_prev,
  input  logic [WIDTH-1:0] i_count,
  output logic [1:0]       o_class,
  output logic             o_wrap_up,
  output logic             o_wrap_down
);
  logic [WIDTH-1:0] w_delta;
  delta_t           w_class;
  assign w_delta = i_count - i_prev;
  assign w_class = (w_delta == '0) ? HOLD :
                   (w_delta == WIDTH'(1)) ? UP :
                   (w_delta == '1) ? DOWN : ILLEGAL;
  assign o_class = w_class;
`ifdef COUNT_MONITOR_WRAP_FLAG_EN
  assign o_wrap_up   = (i_prev == '1) && (i_count == '0);
  assign o_wrap_down = (i_prev == '0) && (i_count == '1);
`else
  assign o_wrap_up   = 1'b0;
  assign o_wrap_down = 1'b0;
`endif
endmodule

// File: rtl/count_monitor.sv
// count_monitor: validates an up/down counter stream and extends it to a signed position
//   i_clk, i_rst_n (async active-low), i_sample_valid, i_count_in[WIDTH]
//   o_dir_out, o_dir_change, o_step_err, o_locked, o_position[ACC_WIDTH],
//   o_err_count[16], o_wrap_up, o_wrap_down
//   Optional wrap pulses enabled by defining COUNT_MONITOR_WRAP_FLAG_EN.
module count_monitor
  import count_monitor_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 32,
  parameter int LOCK_RUN  = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_sample_valid,
  input  logic [WIDTH-1:0]     i_count_in,
  output logic                 o_dir_out,
  output logic                 o_dir_change,
  output logic                 o_step_err,
  output logic                 o_locked,
  output logic [ACC_WIDTH-1:0] o_position,
  output logic [15:0]          o_err_count,
  output logic                 o_wrap_up,
  output logic                 o_wrap_down
);
  state_t               r_state, w_state_nx;
  logic [7:0]           r_run, w_run_nx;
  logic [WIDTH-1:0]     r_prev;
  logic                 r_dir, r_dir_change, r_step_err;
  logic [ACC_WIDTH-1:0] r_position;
  logic [15:0]          r_err_count;
  logic [1:0]           w_class_bits;
  delta_t               w_class;
  logic                 w_active, w_step;
`ifdef COUNT_MONITOR_WRAP_FLAG_EN
  logic w_wrap_up, w_wrap_down, r_wrap_up, r_wrap_down;
`endif
  count_delta_classify #(.WIDTH(WIDTH)) u_classify (
    .i_prev     (r_prev),
    .i_count    (i_count_in),
    .o_class    (w_class_bits),
`ifdef COUNT_MONITOR_WRAP_FLAG_EN
    .o_wrap_up  (w_wrap_up),
    .o_wrap_down(w_wrap_down)
`else
    .o_wrap_up  (o_wrap_up),
    .o_wrap_down(o_wrap_down)
`endif
  );
  assign w_class  = delta_t'(w_class_bits);
  // IDLE samples only seed the reference; they are never classified
  assign w_active = i_sample_valid && (r_state != IDLE);
  assign w_step   = (w_class == UP) || (w_class == DOWN);
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_run   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_run   <= w_run_nx;
    end
  end
  always_comb begin
    w_state_nx = r_state;
    w_run_nx   = r_run;
    if (i_sample_valid) begin
      case (r_state)
        IDLE: w_state_nx = ACQUIRE;
        ACQUIRE: begin
          if (w_step) begin
            w_run_nx   = r_run + 8'd1;
            w_state_nx = (r_run + 8'd1 == 8'(LOCK_RUN)) ? LOCKED : ACQUIRE;
          end else if (w_class == ILLEGAL) begin
            w_run_nx = '0;
          end
        end
        LOCKED: begin
          if (w_class == ILLEGAL) begin
            w_state_nx = ACQUIRE;
            w_run_nx   = '0;
          end
        end
        default: w_state_nx = IDLE;
      endcase
    end
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_prev       <= '0;
      r_dir        <= 1'b1;
      r_dir_change <= 1'b0;
      r_step_err   <= 1'b0;
      r_position   <= '0;
      r_err_count  <= '0;
    end else begin
      r_dir_change <= 1'b0;
      r_step_err   <= 1'b0;
      if (i_sample_valid) r_prev <= i_count_in;
      if (w_active && w_step) begin
        r_dir        <= (w_class == UP);
        r_dir_change <= (w_class == UP) != r_dir;
        r_position   <= (w_class == UP) ? r_position + ACC_WIDTH'(1) : r_position - ACC_WIDTH'(1);
      end
      if (w_active && (w_class == ILLEGAL)) begin
        r_step_err  <= 1'b1;
        r_err_count <= (r_err_count == ERR_COUNT_MAX) ? r_err_count : r_err_count + 16'd1;
      end
    end
  end
`ifdef COUNT_MONITOR_WRAP_FLAG_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wrap_up   <= 1'b0;
      r_wrap_down <= 1'b0;
    end else begin
      r_wrap_up   <= w_active && w_wrap_up;
      r_wrap_down <= w_active && w_wrap_down;
    end
  end
  assign o_wrap_up   = r_wrap_up;
  assign o_wrap_down = r_wrap_down;
`endif
  assign o_dir_out    = r_dir;
  assign o_dir_change = r_dir_change;
  assign o_step_err   = r_step_err;
  assign o_locked     = (r_state == LOCKED);
  assign o_position   = r_position;
  assign o_err_count  = r_err_count;
endmodule

// File: doc/count_monitor.md
# count_monitor

Receive-side checker for the free-running up/down counters in the counter subsystem. It samples a counter value bus and recovers the counting direction from successive samples. It accumulates a wide signed position and flags illegal steps, meaning any jump other than 0 or ±1 modulo 2^WIDTH. It sits downstream of an 8- or 16-bit counter and lets system logic validate the counter and extend it to ACC_WIDTH bits.

## Interface
- WIDTH, 8: width of the observed counter bus.
- ACC_WIDTH, 32: width of the signed position accumulator (must be > WIDTH).
- LOCK_RUN, 4: consecutive legal steps required to enter LOCKED (1..255).
- clk  in  1  single clock; all logic is rising-edge.
- reset  in  1  asynchronous, active-low reset.
- sample_valid  in  1  count_in is valid this cycle.
- count_in  in  WIDTH  observed counter value.
- dir_out  out  1  last non-zero step direction (1 = up, 0 = down).
- dir_change  out  1  one-cycle pulse when a step's direction differs from dir_out.
- step_err  out  1  one-cycle pulse on an illegal step.
- locked  out  1  state == LOCKED.
- position  out  ACC_WIDTH  signed accumulated steps since reset.
- err_count  out  16  illegal steps since reset, saturating at 16'hFFFF.
- wrap_up / wrap_down  out  1  wrap pulses (see Configuration).

## Operation
- Reset values: dir_out=1, dir_change=0, step_err=0, locked=0, position=0, err_count=0, wrap_up=0, wrap_down=0. The internal prev register is 0, run is 0, and the state is IDLE.
- Cycles with sample_valid=0 change nothing.
- Each valid sample computes delta = count_in − prev, modulo 2^WIDTH. Classes:
  - HOLD: delta = 0.
  - UP: delta = 1.
  - DOWN: delta = all ones.
  - ILLEGAL: any other value.
- prev ← count_in on every valid sample, in every state.
- States:
  - IDLE: the first valid sample only loads prev, with no classification. Go to ACQUIRE.
  - ACQUIRE:
    - UP or DOWN: run+1. When run reaches LOCK_RUN, go to LOCKED.
    - HOLD: no change to run.
    - ILLEGAL: run ← 0, stay in ACQUIRE.
  - LOCKED:
    - UP, DOWN or HOLD: stay in LOCKED.
    - ILLEGAL: go to ACQUIRE and set run ← 0.
- UP adds 1 to position and DOWN subtracts 1, in both ACQUIRE and LOCKED. Position wraps in two's complement at ACC_WIDTH with no saturation.
- On UP or DOWN:
  - dir_out is updated to the step's direction.
  - dir_change pulses if the new direction differs from the old dir_out.
  - The first step after reset is compared against the reset value dir_out=1.
- On ILLEGAL:
  - step_err pulses.
  - err_count increments with saturation.
  - position and dir_out do not change.
  - The new sample becomes the reference for the next step (resynchronisation).
- Wrap-around (max→0 is UP, 0→max is DOWN) is a legal step.
- Reset mid-operation returns every register to its reset value immediately, without waiting for a clock edge.

## Timing
- All outputs are registered.
- Every effect of a valid sample at edge N is visible after edge N (one-cycle latency).
- Pulse outputs are high for exactly one cycle per causing sample.
- Back-to-back valid samples every cycle are supported, with full throughput and no stall.
- The locked transition is visible in the same cycle as the step that completes the run.

## Configuration
- COUNT_MONITOR_WRAP_FLAG_EN defined:
  - wrap_up pulses on an UP step from all-ones to 0.
  - wrap_down pulses on a DOWN step from 0 to all-ones.
  - Both are registered with the same latency as the other outputs.
- Macro undefined: wrap_up and wrap_down are tied to 0, no wrap-detect logic is built, and the ports remain present.

## Structure
- Package count_monitor_pkg holds:
  - state enum: IDLE, ACQUIRE, LOCKED.
  - delta-class enum: HOLD, UP, DOWN, ILLEGAL.
  - ERR_COUNT_MAX constant (16'hFFFF).
- Sub-module count_delta_classify: purely combinational, parameterised by WIDTH. It takes prev and count_in and outputs the delta class plus the wrap-up/wrap-down conditions.
- count_monitor holds the FSM, run counter, accumulator, and output registers.

## Test plan
- Reset then samples 5,6,7,8,9, WIDTH=8, LOCK_RUN=4 → locked=1 one cycle after sample 9, position=4, dir_out=1, step_err never asserted.
- Locked, then samples 9,8,7 → dir_change pulse on sample 8 only, position=2, dir_out=0, locked stays 1.
- Locked at 10, sample 14 → step_err pulse, err_count=1, locked=0, position unchanged; then 15,16,17,18 → relock.
- Samples 254,255,0,1 with macro defined → one wrap_up pulse on sample 0, position=3. Samples 1,0,255 → one wrap_down pulse on sample 255. Without the macro → both wrap outputs stay 0.
- Repeated samples 7,7,7 while in ACQUIRE with run=2 → run unchanged, no pulses; sample_valid=0 with count_in toggling → no output change.
- Assert reset for 1 cycle mid-stream while locked with position=100 → all outputs at reset values before the next clock edge; the next valid sample only loads prev (IDLE→ACQUIRE).
